// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive-frame controller.
// State encoding, default start-of-frame byte and the inter-byte timeout limit.
package uart_pkg;

    localparam int ST_W = 3;

    typedef enum logic [ST_W-1:0] {
        IDLE    = 3'd0,
        LEN     = 3'd1,
        PAYLOAD = 3'd2,
        CHK     = 3'd3,
        OUT     = 3'd4
    } state_t;

    localparam logic [7:0] SOF_DEFAULT = 8'hA5;

    // One byte time is 10 bit times (start + 8 data + stop).
    function automatic int unsigned timeout_limit(input int unsigned clock_freq,
                                                  input int unsigned baud_rate,
                                                  input int unsigned timeout_bytes);
        return timeout_bytes * 10 * (clock_freq / baud_rate);
    endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer: DEPTH x 8 register file, one synchronous write port and
// one combinational read port. Storage is not reset; the controller never
// reads an entry it has not written in the current frame.
module uart_frame_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [7:0]    o_rdata
);

    logic [7:0] mem_q [DEPTH];

    // Write one payload byte per accepted strobe.
    always_ff @(posedge clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Frames the UART byte stream: SOF, LEN, LEN payload bytes, CHK (XOR of LEN
// and payload). Good frames are replayed on a valid/ready stream; bad ones are
// dropped with a one-cycle error pulse.
// Optional inter-byte timeout is built only when UART_FRAME_TIMEOUT_EN is defined.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | hunting for SOF, everything else ignored
// LEN     | waiting for the length byte
// PAYLOAD | storing payload bytes into the buffer
// CHK     | waiting for the checksum byte
// OUT     | replaying the buffered payload; new bytes are overflow
module uart_rx_frame_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ    = 50_000_000,
    parameter int unsigned BAUD_RATE     = 9600,
    parameter int unsigned MAX_LEN       = 16,
    parameter logic [7:0]  SOF           = SOF_DEFAULT,
    parameter int unsigned TIMEOUT_BYTES = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [7:0]                   i_rx_data,
    input  logic                         i_rx_valid,
    output logic [7:0]                   o_frm_data,
    output logic                         o_frm_valid,
    input  logic                         i_frm_ready,
    output logic                         o_frm_last,
    output logic [$clog2(MAX_LEN+1)-1:0] o_frm_len,
    output logic                         o_busy,
    output logic                         o_len_err,
    output logic                         o_chk_err,
    output logic                         o_ovf_err,
    output logic                         o_timeout
);

    localparam int          LW        = $clog2(MAX_LEN + 1);
    localparam int          IW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned TMO_LIMIT = timeout_limit(CLOCK_FREQ, BAUD_RATE, TIMEOUT_BYTES);

    if (MAX_LEN < 1 || MAX_LEN > 255) begin : g_bad_max_len
        $error("MAX_LEN must be in 1..255");
    end
    if (TMO_LIMIT < 2) begin : g_bad_tmo_limit
        $error("timeout limit must be at least 2 cycles");
    end

    state_t          state_q, state_d;
    logic [LW-1:0]   len_q, len_d;
    logic [7:0]      chk_q, chk_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [IW-1:0]   rd_q, rd_d;
    logic            len_err_q, len_err_d;
    logic            chk_err_q, chk_err_d;
    logic            ovf_err_q, ovf_err_d;
    logic            buf_we;
    logic [7:0]      buf_rdata;
    logic [LW-1:0]   len_m1;
    logic            frm_valid;
    logic            frm_last;

`ifdef UART_FRAME_TIMEOUT_EN
    localparam int            TW       = $clog2(TMO_LIMIT + 1);
    localparam logic [TW-1:0] TMR_LOAD = TW'(TMO_LIMIT);

    logic [TW-1:0] tmr_q, tmr_d;
    logic          tmo_q, tmo_d;
`endif

    uart_frame_buf #(
        .DEPTH (MAX_LEN),
        .AW    (IW)
    ) u_buf (
        .clk     (clk),
        .i_we    (buf_we),
        .i_waddr (idx_q),
        .i_wdata (i_rx_data),
        .i_raddr (rd_q),
        .o_rdata (buf_rdata)
    );

    assign len_m1    = len_q - LW'(1);
    assign frm_valid = (state_q == OUT);
    assign frm_last  = frm_valid && (LW'(rd_q) == len_m1);

    // Next-state, datapath updates and error-pulse requests.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        chk_d     = chk_q;
        idx_d     = idx_q;
        rd_d      = rd_q;
        len_err_d = 1'b0;
        chk_err_d = 1'b0;
        ovf_err_d = 1'b0;
        buf_we    = 1'b0;
`ifdef UART_FRAME_TIMEOUT_EN
        tmr_d     = tmr_q;
        tmo_d     = 1'b0;
`endif

        unique case (state_q)
            IDLE: begin
                if (i_rx_valid && i_rx_data == SOF) begin
                    chk_d   = '0;
                    state_d = LEN;
                end
            end
            LEN: begin
                if (i_rx_valid) begin
                    if (i_rx_data == 8'd0 || i_rx_data > 8'(MAX_LEN)) begin
                        len_err_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        len_d   = LW'(i_rx_data);
                        chk_d   = i_rx_data;
                        idx_d   = '0;
                        state_d = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (i_rx_valid) begin
                    buf_we = 1'b1;
                    chk_d  = chk_q ^ i_rx_data;
                    idx_d  = idx_q + IW'(1);
                    if (LW'(idx_q) == len_m1) begin
                        state_d = CHK;
                    end
                end
            end
            CHK: begin
                if (i_rx_valid) begin
                    if (i_rx_data == chk_q) begin
                        rd_d    = '0;
                        state_d = OUT;
                    end else begin
                        chk_err_d = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            OUT: begin
                // The receiver cannot be back-pressured, so bytes arriving
                // during replay are lost and reported.
                if (i_rx_valid) begin
                    ovf_err_d = 1'b1;
                end
                if (i_frm_ready) begin
                    if (frm_last) begin
                        state_d = IDLE;
                    end else begin
                        rd_d = rd_q + IW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef UART_FRAME_TIMEOUT_EN
        // Down-counter reloaded on every byte; a byte arriving on the
        // terminal cycle reloads it and so beats the timeout.
        if (state_q == IDLE) begin
            if (state_d == LEN) begin
                tmr_d = TMR_LOAD;
            end
        end else if (state_q inside {LEN, PAYLOAD, CHK}) begin
            if (i_rx_valid) begin
                tmr_d = TMR_LOAD;
            end else if (tmr_q == TW'(1)) begin
                tmo_d   = 1'b1;
                state_d = IDLE;
            end else begin
                tmr_d = tmr_q - TW'(1);
            end
        end
`endif
    end

    // State, datapath and registered error pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            len_q     <= '0;
            chk_q     <= '0;
            idx_q     <= '0;
            rd_q      <= '0;
            len_err_q <= 1'b0;
            chk_err_q <= 1'b0;
            ovf_err_q <= 1'b0;
`ifdef UART_FRAME_TIMEOUT_EN
            tmr_q     <= '0;
            tmo_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            chk_q     <= chk_d;
            idx_q     <= idx_d;
            rd_q      <= rd_d;
            len_err_q <= len_err_d;
            chk_err_q <= chk_err_d;
            ovf_err_q <= ovf_err_d;
`ifdef UART_FRAME_TIMEOUT_EN
            tmr_q     <= tmr_d;
            tmo_q     <= tmo_d;
`endif
        end
    end

    // Data and length are gated so nothing leaks from the unreset buffer.
    assign o_frm_valid = frm_valid;
    assign o_frm_data  = frm_valid ? buf_rdata : 8'd0;
    assign o_frm_last  = frm_last;
    assign o_frm_len   = frm_valid ? len_q : '0;
    assign o_busy      = (state_q != IDLE);
    assign o_len_err   = len_err_q;
    assign o_chk_err   = chk_err_q;
    assign o_ovf_err   = ovf_err_q;
`ifdef UART_FRAME_TIMEOUT_EN
    assign o_timeout   = tmo_q;
`else
    assign o_timeout   = 1'b0;
`endif

endmodule
